jpeg_bitstream_packer: RTL and testbench

Receiving end of the Huffman encoder controller's symbol output interface. It captures each symbol record on jpeg_out_enable into a small FIFO and serializes the variable-length segments MSB-first into a byte stream. The segments are the DC Huffman code, the DC amplitude bits, the AC Huffman code and the AC amplitude bits. It inserts JPEG 0x00 stuffing after every 0xFF byte and pads with 1s to a byte boundary on flush. It sits between the Huffman encoder controller and the JFIF stream writer.

---
 rtl/jpeg_bitstream_packer.sv | 203 ++++++++++++++++++++
 tb/tb_jpeg_bitstream_packer.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jpeg_bitstream_packer.sv
// Buffers Huffman symbol records and packs their code/amplitude segments MSB-first
// into a JPEG byte stream, with 0xFF/0x00 stuffing and 1-padding on flush.
module jpeg_bitstream_packer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        jpeg_out_enable,
    input  logic        jpeg_out_end,
    input  logic [8:0]  jpeg_dc_out,
    input  logic [7:0]  jpeg_dc_out_length,
    input  logic [7:0]  jpeg_dc_code_list,
    input  logic [7:0]  jpeg_dc_code_size,
    input  logic [15:0] huffman_code,
    input  logic [7:0]  huffman_code_length,
    input  logic [7:0]  code_out,
    input  logic [7:0]  code_size_out,
    input  logic        flush_req,
    output logic [7:0]  byte_out,
    output logic        byte_valid,
    input  logic        byte_ready,
    output logic        in_ready,
    output logic        busy,
    output logic        flush_done,
    output logic        overflow,
    output logic [3:0]  debug_state
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [3:0] {
        S_IDLE, S_DC_CODE, S_DC_AMP, S_AC_CODE, S_AC_AMP,
        S_DRAIN, S_STUFF, S_PAD, S_FLUSH_DRAIN, S_FLUSH_STUFF
    } state_t;

    // Lengths are stored already saturated to their field widths.
    typedef struct packed {
        logic [8:0]  dc_code;
        logic [4:0]  dc_len;
        logic [7:0]  dc_amp;
        logic [4:0]  dc_size;
        logic [15:0] ac_code;
        logic [4:0]  ac_len;
        logic [7:0]  ac_amp;
        logic [4:0]  ac_size;
    } rec_t;

    function automatic logic [4:0] sat_len(input logic [7:0] len, input logic [4:0] lim);
        return (len > {3'b000, lim}) ? lim : len[4:0];
    endfunction

    rec_t          mem [FIFO_DEPTH];
    logic          first_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_count;
    logic          first_flag;
    logic          full, empty, push, pop;
    rec_t          new_rec, cur;

    state_t        state, resume;
    logic [31:0]   acc;
    logic [5:0]    cnt;
    logic          flush_pending;

    logic [15:0]   seg_val;
    logic [4:0]    seg_len;
    logic [31:0]   seg_mask;
    logic [5:0]    shamt;
    logic [31:0]   acc_app;
    logic [5:0]    cnt_app;

    assign full  = (fifo_count == FIFO_DEPTH[AW:0]);
    assign empty = (fifo_count == '0);
    assign pop   = (state == S_IDLE) && !empty;
    // A pop in the same cycle frees a slot, so a strobe on a full FIFO still lands.
    assign push  = jpeg_out_enable && (!full || pop);

    always_comb begin
        new_rec.dc_code = jpeg_dc_out;
        new_rec.dc_len  = sat_len(jpeg_dc_out_length, 5'd9);
        new_rec.dc_amp  = jpeg_dc_code_list;
        new_rec.dc_size = sat_len(jpeg_dc_code_size, 5'd8);
        new_rec.ac_code = huffman_code;
        new_rec.ac_len  = sat_len(huffman_code_length, 5'd16);
        new_rec.ac_amp  = code_out;
        new_rec.ac_size = sat_len(code_size_out, 5'd8);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr]       <= new_rec;
            first_mem[wr_ptr] <= first_flag;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            first_flag <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr     <= wr_ptr + 1'b1;
                first_flag <= jpeg_out_end;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) fifo_count <= fifo_count + 1'b1;
            else if (!push && pop) fifo_count <= fifo_count - 1'b1;
            if (jpeg_out_enable && !push) overflow <= 1'b1;
        end
    end

    // Valid bits sit left-aligned in acc; a new segment lands just below them.
    always_comb begin
        seg_val = '0;
        seg_len = '0;
        case (state)
            S_DC_CODE: begin seg_val = {7'b0, cur.dc_code}; seg_len = cur.dc_len;  end
            S_DC_AMP:  begin seg_val = {8'b0, cur.dc_amp};  seg_len = cur.dc_size; end
            S_AC_CODE: begin seg_val = cur.ac_code;         seg_len = cur.ac_len;  end
            S_AC_AMP:  begin seg_val = {8'b0, cur.ac_amp};  seg_len = cur.ac_size; end
            S_PAD: begin
                seg_val = 16'hFFFF;
                seg_len = (cnt[2:0] == 3'd0) ? 5'd0 : (5'd8 - {2'b00, cnt[2:0]});
            end
            default: ;
        endcase
        seg_mask = (32'h1 << seg_len) - 32'h1;
        shamt    = 6'd32 - cnt - {1'b0, seg_len};
        acc_app  = acc | (({16'h0000, seg_val} & seg_mask) << shamt);
        cnt_app  = cnt + {1'b0, seg_len};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= S_IDLE;
            resume        <= S_IDLE;
            acc           <= '0;
            cnt           <= '0;
            cur           <= '0;
            flush_pending <= 1'b0;
            flush_done    <= 1'b0;
        end else begin
            flush_done <= 1'b0;
            if (flush_req) flush_pending <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (!empty) begin
                        cur   <= mem[rd_ptr];
                        state <= first_mem[rd_ptr] ? S_DC_CODE : S_AC_CODE;
                    end else if (flush_pending) begin
                        flush_pending <= 1'b0;
                        state         <= S_PAD;
                    end
                end
                S_DC_CODE, S_DC_AMP, S_AC_CODE, S_AC_AMP: begin
                    acc   <= acc_app;
                    cnt   <= cnt_app;
                    state <= S_DRAIN;
                    case (state)
                        S_DC_CODE: resume <= S_DC_AMP;
                        S_DC_AMP:  resume <= S_AC_CODE;
                        S_AC_CODE: resume <= S_AC_AMP;
                        default:   resume <= S_IDLE;
                    endcase
                end
                S_PAD: begin
                    acc   <= acc_app;
                    cnt   <= cnt_app;
                    state <= S_FLUSH_DRAIN;
                end
                S_DRAIN, S_FLUSH_DRAIN: begin
                    if (cnt >= 6'd8) begin
                        if (byte_ready) begin
                            acc <= {acc[23:0], 8'h00};
                            cnt <= cnt - 6'd8;
                            if (acc[31:24] == 8'hFF)
                                state <= (state == S_DRAIN) ? S_STUFF : S_FLUSH_STUFF;
                        end
                    end else if (state == S_DRAIN) begin
                        state <= resume;
                    end else begin
                        flush_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_STUFF:       if (byte_ready) state <= S_DRAIN;
                S_FLUSH_STUFF: if (byte_ready) state <= S_FLUSH_DRAIN;
                default:       state <= S_IDLE;
            endcase
        end
    end

    // Byte handshake: a byte moves on a rising edge with byte_valid & byte_ready;
    // while byte_ready is low, byte_valid and byte_out hold their values.
    assign byte_valid  = (((state == S_DRAIN) || (state == S_FLUSH_DRAIN)) && (cnt >= 6'd8))
                         || (state == S_STUFF) || (state == S_FLUSH_STUFF);
    assign byte_out    = ((state == S_STUFF) || (state == S_FLUSH_STUFF)) ? 8'h00 : acc[31:24];
    assign in_ready    = !full;
    assign busy        = !empty || (state != S_IDLE) || flush_pending;
    assign debug_state = state;
endmodule

// File: tb/tb_jpeg_bitstream_packer.sv
// Randomized bench for jpeg_bitstream_packer, checked against a bit-queue model
// of segment concatenation, byte stuffing and flush padding.
module tb_jpeg_bitstream_packer;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        jpeg_out_enable = 1'b0;
    logic        jpeg_out_end = 1'b0;
    logic [8:0]  jpeg_dc_out = '0;
    logic [7:0]  jpeg_dc_out_length = '0;
    logic [7:0]  jpeg_dc_code_list = '0;
    logic [7:0]  jpeg_dc_code_size = '0;
    logic [15:0] huffman_code = '0;
    logic [7:0]  huffman_code_length = '0;
    logic [7:0]  code_out = '0;
    logic [7:0]  code_size_out = '0;
    logic        flush_req = 1'b0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        in_ready;
    logic        busy;
    logic        flush_done;
    logic        overflow;
    logic [3:0]  debug_state;

    jpeg_bitstream_packer #(.FIFO_DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .jpeg_out_enable(jpeg_out_enable), .jpeg_out_end(jpeg_out_end),
        .jpeg_dc_out(jpeg_dc_out), .jpeg_dc_out_length(jpeg_dc_out_length),
        .jpeg_dc_code_list(jpeg_dc_code_list), .jpeg_dc_code_size(jpeg_dc_code_size),
        .huffman_code(huffman_code), .huffman_code_length(huffman_code_length),
        .code_out(code_out), .code_size_out(code_size_out),
        .flush_req(flush_req), .byte_out(byte_out), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .in_ready(in_ready), .busy(busy),
        .flush_done(flush_done), .overflow(overflow), .debug_state(debug_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [8:0]  dc;
        logic [7:0]  dc_len;
        logic [7:0]  dc_amp;
        logic [7:0]  dc_size;
        logic [15:0] ac;
        logic [7:0]  ac_len;
        logic [7:0]  ac_amp;
        logic [7:0]  ac_size;
        logic        last;
    } rec_t;

    logic [7:0] exp_q[$];
    logic [7:0] got_bytes[$];
    bit         bits_q[$];
    bit         model_first = 1'b1;
    int         n_checks = 0;
    int         n_errors = 0;
    int         n_flush_exp = 0;
    int         n_flush_seen = 0;
    int         ready_mode = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_put(input logic [15:0] v, input int len, input int maxw);
        int n;
        n = (len > maxw) ? maxw : len;
        for (int i = n - 1; i >= 0; i--) bits_q.push_back(v[i]);
    endtask

    task automatic model_pack();
        while (bits_q.size() >= 8) begin
            logic [7:0] b;
            b = '0;
            for (int k = 0; k < 8; k++) b = {b[6:0], bits_q.pop_front()};
            exp_q.push_back(b);
            if (b == 8'hFF) exp_q.push_back(8'h00);
        end
    endtask

    task automatic model_record(input rec_t r);
        if (model_first) begin
            model_put({7'b0, r.dc}, r.dc_len, 9);
            model_put({8'b0, r.dc_amp}, r.dc_size, 8);
        end
        model_put(r.ac, r.ac_len, 16);
        model_put({8'b0, r.ac_amp}, r.ac_size, 8);
        model_first = r.last;
        model_pack();
    endtask

    task automatic model_flush();
        while ((bits_q.size() % 8) != 0) bits_q.push_back(1'b1);
        model_pack();
        n_flush_exp++;
    endtask

    function automatic rec_t rand_rec(input logic last);
        rec_t r;
        r.dc      = 9'($urandom);
        r.dc_len  = 8'($urandom_range(0, 11));
        r.dc_amp  = 8'($urandom);
        r.dc_size = 8'($urandom_range(0, 10));
        r.ac      = 16'($urandom);
        r.ac_len  = 8'($urandom_range(0, 18));
        r.ac_amp  = 8'($urandom);
        r.ac_size = 8'($urandom_range(0, 10));
        r.last    = last;
        return r;
    endfunction

    // ---------------- drivers ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic strobe(input rec_t r);
        jpeg_out_enable     = 1'b1;
        jpeg_out_end        = r.last;
        jpeg_dc_out         = r.dc;
        jpeg_dc_out_length  = r.dc_len;
        jpeg_dc_code_list   = r.dc_amp;
        jpeg_dc_code_size   = r.dc_size;
        huffman_code        = r.ac;
        huffman_code_length = r.ac_len;
        code_out            = r.ac_amp;
        code_size_out       = r.ac_size;
        step();
        jpeg_out_enable     = 1'b0;
        jpeg_out_end        = 1'b0;
    endtask

    task automatic send(input rec_t r);
        int w;
        w = 0;
        while (!in_ready && w < 2000) begin step(); w++; end
        if (w >= 2000) check("in_ready_timeout", in_ready, 1);
        strobe(r);
        model_record(r);
    endtask

    task automatic do_flush();
        flush_req = 1'b1;
        step();
        flush_req = 1'b0;
        model_flush();
    endtask

    task automatic run_until_done();
        int w;
        w = 0;
        while ((busy || exp_q.size() != 0 || n_flush_seen != n_flush_exp) && w < 5000) begin
            step();
            w++;
        end
        check("drain_bytes_left", exp_q.size(), 0);
        check("flush_count", n_flush_seen, n_flush_exp);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #1;
            case (ready_mode)
                0:       byte_ready = 1'b1;
                1:       byte_ready = 1'($urandom_range(0, 1));
                default: byte_ready = 1'b0;
            endcase
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        logic       prev_valid, prev_ready, prev_reset;
        logic [7:0] prev_byte;
        prev_valid = 1'b0; prev_ready = 1'b0; prev_reset = 1'b1; prev_byte = '0;
        forever begin
            @(negedge clock);
            if (prev_valid && !prev_ready && !prev_reset) begin
                check("hold_valid", byte_valid, 1);
                check("hold_byte", byte_out, prev_byte);
            end
            if (byte_valid && byte_ready && !reset) begin
                got_bytes.push_back(byte_out);
                check("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("byte_value", byte_out, exp_q.pop_front());
            end
            if (flush_done) begin
                n_flush_seen++;
                check("flush_residue", exp_q.size(), 0);
            end
            prev_valid = byte_valid;
            prev_ready = byte_ready;
            prev_reset = reset;
            prev_byte  = byte_out;
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        rec_t r;

        repeat (3) step();
        reset = 1'b0;
        @(negedge clock);
        check("rst_byte_valid", byte_valid, 0);
        check("rst_byte_out", byte_out, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_flush_done", flush_done, 0);
        check("rst_overflow", overflow, 0);
        step();

        // single first record, flushed to one padded byte
        got_bytes.delete();
        r = '{dc: 9'h000, dc_len: 8'd2, dc_amp: 8'h00, dc_size: 8'd0,
              ac: 16'h000A, ac_len: 8'd4, ac_amp: 8'h00, ac_size: 8'd0, last: 1'b1};
        send(r);
        do_flush();
        run_until_done();
        check("t1_nbytes", got_bytes.size(), 1);
        if (got_bytes.size() >= 1) check("t1_byte", got_bytes[0], 8'h2B);

        // 0xFF stuffing, then a flush on an empty accumulator
        got_bytes.delete();
        r = '{dc: 9'h1FF, dc_len: 8'd0, dc_amp: 8'hFF, dc_size: 8'd0,
              ac: 16'hFFFF, ac_len: 8'd16, ac_amp: 8'hFF, ac_size: 8'd0, last: 1'b1};
        send(r);
        do_flush();
        run_until_done();
        check("t2_nbytes", got_bytes.size(), 4);
        if (got_bytes.size() >= 4) begin
            check("t2_b0", got_bytes[0], 8'hFF);
            check("t2_b1", got_bytes[1], 8'h00);
            check("t2_b2", got_bytes[2], 8'hFF);
            check("t2_b3", got_bytes[3], 8'h00);
        end

        // two blocks of two records each
        ready_mode = 1;
        for (int i = 0; i < 4; i++) send(rand_rec(i == 1 || i == 3));
        do_flush();
        run_until_done();

        // random blocks with random gaps and backpressure
        for (int blk = 0; blk < 8; blk++) begin
            int nrec;
            nrec = $urandom_range(1, 6);
            for (int i = 0; i < nrec; i++) begin
                repeat ($urandom_range(0, 3)) step();
                send(rand_rec(i == nrec - 1));
            end
            if (blk % 2 == 1) do_flush();
            run_until_done();
        end
        do_flush();
        run_until_done();

        // long stall mid-stream
        ready_mode = 0;
        for (int i = 0; i < 3; i++) send(rand_rec(i == 2));
        repeat (3) step();
        ready_mode = 2;
        repeat (20) step();
        ready_mode = 0;
        do_flush();
        run_until_done();

        // overflow: first record stalls the engine, four fill the FIFO, sixth drops
        ready_mode = 2;
        repeat (2) step();
        for (int k = 1; k <= 6; k++) begin
            r = rand_rec(1'($urandom_range(0, 1)));
            if (k == 1) r.ac_len = 8'd16;
            strobe(r);
            if (k <= 5) model_record(r);
            repeat (7) step();
            @(negedge clock);
            check($sformatf("ovf_in_ready_%0d", k), in_ready, (k < 5) ? 1 : 0);
            check($sformatf("ovf_flag_%0d", k), overflow, (k >= 6) ? 1 : 0);
            step();
        end
        ready_mode = 1;
        do_flush();
        run_until_done();
        check("ovf_sticky", overflow, 1);

        // reset in the middle of draining
        ready_mode = 2;
        repeat (2) step();
        r = rand_rec(1'b1);
        r.ac_len = 8'd16;
        send(r);
        begin
            int w;
            w = 0;
            while (!byte_valid && w < 40) begin step(); w++; end
        end
        check("rst_pre_valid", byte_valid, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        @(negedge clock);
        check("mid_rst_byte_valid", byte_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_overflow", overflow, 0);
        exp_q.delete();
        bits_q.delete();
        model_first = 1'b1;
        step();
        ready_mode = 0;
        got_bytes.delete();
        r = rand_rec(1'b1);
        r.dc_len = 8'd7;
        send(r);
        do_flush();
        run_until_done();
        check("post_rst_nbytes", got_bytes.size() != 0, 1);

        repeat (5) step();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
